alu_operand_sel_pipe: RTL and testbench

//  Execute-stage operand selector, successor to the fixed 24-bit 3:1 ALU mux.

---
 rtl/alu_operand_sel_pipe_if.sv | 31 +++
 rtl/alu_operand_sel_pipe.sv | 108 ++++++++++
 tb/tb_alu_operand_sel_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sel_pipe_if.sv
// Handshake and data bus for the execute-stage operand selector.
// The master side drives the sources/selects and consumes operands; the slave side is the selector.
interface alu_operand_sel_pipe_if #(
  parameter int WIDTH = 24,
  parameter int NSRC  = 3,
  parameter int NCH   = 2,
  parameter int CNT_W = 8
);
  localparam int SEL_W = $clog2(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NCH*SEL_W-1:0]  sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [NCH*WIDTH-1:0]  out_data;
  logic [NCH-1:0]        out_sel_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      err_count;

  modport master (
    output src_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel_err, out_valid, err_count
  );

  modport slave (
    input  src_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel_err, out_valid, err_count
  );
endinterface

// File: rtl/alu_operand_sel_pipe.sv
// Execute-stage operand selector: per-lane NSRC:1 mux at the input, registered
// through a main/skid register pair with valid/ready handshake and error counting.
module alu_operand_sel_pipe #(
  parameter int WIDTH = 24,
  parameter int NSRC  = 3,
  parameter int NCH   = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_operand_sel_pipe_if.slave bus
);
  localparam int SEL_W = $clog2(NSRC);

  logic [NCH*WIDTH-1:0] mux_data;
  logic [NCH-1:0]       mux_err;

  logic                 m_valid_q, m_valid_d;
  logic [NCH*WIDTH-1:0] m_data_q,  m_data_d;
  logic [NCH-1:0]       m_err_q,   m_err_d;
  logic                 s_valid_q, s_valid_d;
  logic [NCH*WIDTH-1:0] s_data_q,  s_data_d;
  logic [NCH-1:0]       s_err_q,   s_err_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;

  logic accept;

  // Out-of-range selects fall through the loop and keep the zero data / error defaults.
  always_comb begin
    mux_data = '0;
    mux_err  = '1;
    for (int unsigned j = 0; j < NCH; j++) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        if (bus.sel[j*SEL_W +: SEL_W] == SEL_W'(k)) begin
          mux_data[j*WIDTH +: WIDTH] = bus.src_data[k*WIDTH +: WIDTH];
          mux_err[j]                 = 1'b0;
        end
      end
    end
  end

  assign accept = bus.in_valid && !s_valid_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_err_d   = m_err_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_err_d   = s_err_q;
    err_cnt_d = err_cnt_q;

    if (bus.flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (!m_valid_q || bus.out_ready) begin
        // accept is impossible while S holds a beat, so draining S never loses input.
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          m_err_d   = s_err_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = accept;
          if (accept) begin
            m_data_d = mux_data;
            m_err_d  = mux_err;
          end
        end
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = mux_data;
        s_err_d   = mux_err;
      end

      if (accept && (|mux_err) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_err_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_err_q   <= m_err_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_err_q   <= s_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready    = !s_valid_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.out_data    = m_data_q;
  assign bus.out_sel_err = m_err_q;
  assign bus.err_count   = err_cnt_q;
endmodule

// File: tb/tb_alu_operand_sel_pipe.sv
// Directed bench for alu_operand_sel_pipe: scoreboard of expected operands,
// pushed on accepted beats and compared on consumed beats.
module tb_alu_operand_sel_pipe;
  logic clk;
  logic rst_n;

  alu_operand_sel_pipe_if #(.WIDTH(24), .NSRC(3), .NCH(2), .CNT_W(8)) bus ();

  alu_operand_sel_pipe #(.WIDTH(24), .NSRC(3), .NCH(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int popped     = 0;
  int exp_cnt    = 0;

  logic [49:0] q[$];
  logic        hold_pend = 1'b0;
  logic [49:0] hold_val;

  // Expected {err[1:0], laneB, laneA} for a source vector and packed selects.
  function automatic logic [49:0] model(input logic [71:0] src, input logic [3:0] s);
    logic [49:0] r;
    logic [1:0]  v;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      v = s[j*2 +: 2];
      case (v)
        2'd0:    r[j*24 +: 24] = src[23:0];
        2'd1:    r[j*24 +: 24] = src[47:24];
        2'd2:    r[j*24 +: 24] = src[71:48];
        default: r[48+j]       = 1'b1;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Account for the handshakes of the coming edge, then advance to the next negedge.
  task automatic cycle();
    logic [49:0] cur;
    logic [49:0] e;
    cur = {bus.out_sel_err, bus.out_data};
    if (hold_pend) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(cur), 64'(hold_val));
    end
    hold_pend = 1'b0;
    if (bus.flush) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_beat_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_beat", 64'(cur), 64'(e));
        end
        popped++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        hold_pend = 1'b1;
        hold_val  = cur;
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.src_data, bus.sel);
        q.push_back(e);
        if ((|e[49:48]) && exp_cnt != 255) exp_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    repeat (n) cycle();
    chk("sb_drained", 64'(q.size()), 64'd0);
    chk("err_count", 64'(bus.err_count), 64'(exp_cnt));
  endtask

  int b;
  int p0;
  logic acc;

  initial begin
    rst_n        = 1'b0;
    bus.src_data = '0;
    bus.sel      = '0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic select: A=src1, B=src2
    bus.src_data  = {24'h000033, 24'h000022, 24'h000011};
    bus.sel       = {2'd2, 2'd1};
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("sel_out_valid", 64'(bus.out_valid), 64'd1);
    chk("sel_out_data", 64'(bus.out_data), 64'h000033_000022);
    chk("sel_out_err", 64'(bus.out_sel_err), 64'd0);
    drain(2);

    // Invalid select on lane A
    bus.sel      = {2'd0, 2'd3};
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("inv_out_err", 64'(bus.out_sel_err), 64'h1);
    chk("inv_lane_a", 64'(bus.out_data[23:0]), 64'h0);
    chk("inv_lane_b", 64'(bus.out_data[47:24]), 64'h000011);
    chk("inv_err_count", 64'(bus.err_count), 64'd1);
    drain(2);

    // Backpressure: beats 1..6, out_ready low for cycles 2-5
    b = 1;
    p0 = popped;
    bus.sel = {2'd1, 2'd0};
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.in_valid  = (b <= 6);
      bus.src_data  = {24'(b * 3), 24'(b * 2 + 8'h40), 24'(b)};
      bus.out_ready = !(cyc >= 2 && cyc <= 5);
      if (cyc == 2) chk("bp_in_ready_hi", 64'(bus.in_ready), 64'd1);
      if (cyc >= 3 && cyc <= 6) chk("bp_in_ready_lo", 64'(bus.in_ready), 64'd0);
      acc = bus.in_valid && bus.in_ready;
      cycle();
      if (acc) b++;
    end
    drain(3);
    chk("bp_beats_in", 64'(b), 64'd7);
    chk("bp_beats_out", 64'(popped - p0), 64'd6);

    // Flush with M and S full and an erroneous incoming beat
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = {2'd2, 2'd0};
    bus.src_data  = {24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC};
    cycle();
    bus.src_data  = {24'h111111, 24'h222222, 24'h333333};
    cycle();
    chk("fl_full_in_ready", 64'(bus.in_ready), 64'd0);
    p0 = exp_cnt;
    bus.flush = 1'b1;
    bus.sel   = {2'd3, 2'd3};
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    chk("fl_err_count", 64'(bus.err_count), 64'(p0));
    p0 = popped;
    bus.sel       = {2'd0, 2'd1};
    bus.src_data  = {24'h0F0F0F, 24'h5A5A5A, 24'hA5A5A5};
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    drain(3);
    chk("fl_beats_out", 64'(popped - p0), 64'd1);

    // Full throughput for 100 cycles
    p0 = popped;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.src_data  = {24'($urandom), 24'($urandom), 24'($urandom)};
      bus.sel       = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      chk("tp_in_ready", 64'(bus.in_ready), 64'd1);
      if (i > 0) chk("tp_out_valid", 64'(bus.out_valid), 64'd1);
      cycle();
    end
    drain(3);
    chk("tp_beats_out", 64'(popped - p0), 64'd100);

    // Saturation of the error counter
    bus.sel = {2'd0, 2'd3};
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.src_data  = {24'($urandom), 24'($urandom), 24'($urandom)};
      cycle();
    end
    drain(3);
    chk("sat_err_count", 64'(bus.err_count), 64'd255);

    // Asynchronous reset mid-transfer with M and S full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = {2'd1, 2'd2};
    bus.src_data  = {24'h123456, 24'h654321, 24'hFEDCBA};
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_out_data", 64'(bus.out_data), 64'd0);
    chk("mrst_out_err", 64'(bus.out_sel_err), 64'd0);
    chk("mrst_err_count", 64'(bus.err_count), 64'd0);
    q.delete();
    exp_cnt   = 0;
    hold_pend = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
